// File: rtl/nvram_upload_server_if.sv
// HPS upload bus plus core RAM read port, bundled for nvram_upload_server.
// The slave modport is the server's view; the master modport is the
// HPS/core side that drives requests and returns RAM data.
interface nvram_upload_server_if #(
  parameter int AW = 16
);
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ioctl_upload_req;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_q,
    output ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_rd
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_q,
    input  ioctl_din, ioctl_wait, ioctl_upload_req, ram_addr, ram_rd
  );
endinterface

// File: rtl/nvram_upload_server.sv
// nvram_upload_server: answers HPS upload requests for image INDEX by
// reading bytes from a core RAM port while the core CPU is held paused.
// Addresses at or beyond LEN read back as 8'hFF without touching the RAM.
// Optional feature macro: UPLOAD_AUTOREQ_EN -- when defined, writes to the
// monitored RAM arm a settle counter that raises a one-cycle
// ioctl_upload_req once the RAM has been quiet for SETTLE cycles.
module nvram_upload_server #(
  parameter int          AW     = 16,
  parameter logic [15:0] LEN    = 16'd1024,
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter logic [23:0] SETTLE = 24'd3_200_000
) (
  input  logic                  clk_sys,
  input  logic                  RESET_n,
  nvram_upload_server_if.slave  bus,
  output logic                  pause_req,
  input  logic                  paused,
  input  logic                  ram_wr_mon,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAUSE = 3'd1,
    S_READY = 3'd2,
    S_FETCH = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          upload_prev_q;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          pause_q, pause_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          start_s;
  logic          in_range_s;
  logic          done_s;

  // Only a fresh rising edge of the upload level for our index starts a session.
  assign start_s    = bus.ioctl_upload && !upload_prev_q && (bus.ioctl_index == INDEX);
  // Full 25-bit compare so high address bits can never alias into the RAM.
  assign in_range_s = (bus.ioctl_addr < {9'd0, LEN});

  // Upload session sequencing: pause handshake, byte fetch and teardown.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wait_d     = wait_q;
    pause_d    = pause_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = ram_rd_q;
    done_s     = 1'b0;
    if ((state_q != S_IDLE) && (state_q != S_DONE) && !bus.ioctl_upload) begin
      // HPS ended the upload: release the bus at once, unpause next cycle.
      state_d  = S_DONE;
      ram_rd_d = 1'b0;
      wait_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_d = S_PAUSE;
            pause_d = 1'b1;
            wait_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PAUSE: begin
          pause_d = 1'b1;
          if (paused) begin
            state_d = S_READY;
            wait_d  = 1'b0;
          end else begin
            wait_d  = 1'b1;
          end
        end
        S_READY: begin
          if (bus.ioctl_rd && in_range_s) begin
            state_d    = S_FETCH;
            ram_addr_d = bus.ioctl_addr[AW-1:0];
            ram_rd_d   = 1'b1;
            wait_d     = 1'b1;
          end else if (bus.ioctl_rd) begin
            din_d  = 8'hFF;
            wait_d = 1'b0;
          end else begin
            wait_d = 1'b0;
          end
        end
        S_FETCH: begin
          ram_rd_d = 1'b0;
          state_d  = S_LATCH;
        end
        S_LATCH: begin
          din_d   = bus.ram_q;
          wait_d  = 1'b0;
          state_d = S_READY;
        end
        S_DONE: begin
          pause_d = 1'b0;
          wait_d  = 1'b0;
          state_d = S_IDLE;
          done_s  = 1'b1;
        end
        default: begin
          state_d  = S_IDLE;
          pause_d  = 1'b0;
          wait_d   = 1'b0;
          ram_rd_d = 1'b0;
        end
      endcase
    end
  end

  // Session state and bus-facing output registers.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= S_IDLE;
      upload_prev_q <= 1'b0;
      din_q         <= 8'd0;
      wait_q        <= 1'b0;
      pause_q       <= 1'b0;
      ram_addr_q    <= '0;
      ram_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      upload_prev_q <= bus.ioctl_upload;
      din_q         <= din_d;
      wait_q        <= wait_d;
      pause_q       <= pause_d;
      ram_addr_q    <= ram_addr_d;
      ram_rd_q      <= ram_rd_d;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_rd     = ram_rd_q;
  assign pause_req      = pause_q;
  assign busy           = (state_q != S_IDLE);

`ifdef UPLOAD_AUTOREQ_EN
  logic        dirty_q, dirty_d;
  logic [23:0] settle_q, settle_d;
  logic        req_q, req_d;

  // Dirty tracking: a write (re)arms the quiet-time counter, which only runs
  // while no upload is active; a finished upload clears dirty unless a write
  // lands on that very cycle.
  always_comb begin
    dirty_d  = dirty_q;
    settle_d = settle_q;
    req_d    = 1'b0;
    if (ram_wr_mon) begin
      dirty_d  = 1'b1;
      settle_d = SETTLE;
    end else if (done_s) begin
      dirty_d  = 1'b0;
      settle_d = 24'd0;
    end else if (dirty_q && (state_q == S_IDLE) && (settle_q != 24'd0)) begin
      settle_d = settle_q - 24'd1;
      req_d    = (settle_q == 24'd1);
    end else begin
      settle_d = settle_q;
    end
  end

  // Dirty flag, settle counter and request pulse registers.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dirty_q  <= 1'b0;
      settle_q <= 24'd0;
      req_q    <= 1'b0;
    end else begin
      dirty_q  <= dirty_d;
      settle_q <= settle_d;
      req_q    <= req_d;
    end
  end

  assign bus.ioctl_upload_req = req_q;
`else
  logic unused_s;

  assign unused_s             = ram_wr_mon ^ done_s;
  assign bus.ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_upload_server.sv
// Bench for nvram_upload_server: directed handshake/abort/reset scenarios
// plus randomized reads scored against a byte-array reference of the RAM.
module tb_nvram_upload_server;
  localparam int          AW    = 16;
  localparam logic [24:0] LEN_W = 25'd1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pause_req;
  logic paused;
  logic ram_wr_mon;
  logic busy;

  nvram_upload_server_if #(.AW(AW)) bus ();

  nvram_upload_server #(
    .AW(AW), .LEN(16'd1024), .INDEX(8'd4), .SETTLE(24'd20)
  ) dut (
    .clk_sys   (clk),
    .RESET_n   (rst_n),
    .bus       (bus),
    .pause_req (pause_req),
    .paused    (paused),
    .ram_wr_mon(ram_wr_mon),
    .busy      (busy)
  );

  // Core-side RAM: data is valid one cycle after a read enable.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (!rst_n) bus.ram_q <= 8'd0;
    else if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          wait_cycles;
    int          ram_reads;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: in-range bytes come from the RAM after a two-cycle wait,
  // anything else reads 8'hFF at once with no RAM access.
  function automatic exp_t model_read(input logic [24:0] a);
    exp_t e;
    e.addr = a;
    if (a < LEN_W) begin
      e.din = mem[a[15:0]];
      e.wait_cycles = 2;
      e.ram_reads = 1;
    end else begin
      e.din = 8'hFF;
      e.wait_cycles = 0;
      e.ram_reads = 0;
    end
    return e;
  endfunction

  // Monitor: on each scored read strobe, follow the wait window and compare.
  initial begin : monitor
    forever begin
      @(posedge clk);
      if (mon_en && bus.ioctl_rd) begin
        int            waitc;
        int            rdc;
        bit            done;
        exp_t          e;
        logic [AW-1:0] seen_addr;
        waitc = 0;
        rdc = 0;
        done = 1'b0;
        seen_addr = '0;
        #1;
        for (int k = 0; k < 8 && !done; k++) begin
          if (bus.ram_rd) begin
            rdc++;
            seen_addr = bus.ram_addr;
          end
          if (!bus.ioctl_wait) done = 1'b1;
          else begin
            waitc++;
            @(posedge clk);
            #1;
          end
        end
        chk("rd_timeout", 32'(done), 32'd1);
        if (sb_q.size() == 0) begin
          chk("sb_output_without_expect", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("rd_din", 32'(bus.ioctl_din), 32'(e.din));
          chk("rd_wait_cycles", 32'(waitc), 32'(e.wait_cycles));
          chk("rd_ram_reads", 32'(rdc), 32'(e.ram_reads));
          if (e.ram_reads == 1) chk("rd_ram_addr", 32'(seen_addr), 32'(e.addr[15:0]));
        end
      end
    end
  end

  task automatic do_read(input logic [24:0] a, input bit spurious);
    sb_q.push_back(model_read(a));
    @(negedge clk);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    if (spurious) begin
      // Strobe during FETCH must be ignored.
      bus.ioctl_addr = a ^ 25'h3;
      bus.ioctl_rd   = 1'b1;
      @(negedge clk);
    end
    bus.ioctl_rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_upload();
    @(negedge clk);
    bus.ioctl_index  = 8'd4;
    bus.ioctl_upload = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [24:0] a;
    int          r;
    int          pulses;
    int          pulse_at;
    rst_n = 1'b0;
    paused = 1'b0;
    ram_wr_mon = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA7;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", 32'(bus.ioctl_din), 32'd0);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_req", 32'(bus.ioctl_upload_req), 32'd0);
    chk("rst_pause", 32'(pause_req), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrong index is ignored
    @(negedge clk);
    bus.ioctl_index = 8'd0;
    bus.ioctl_upload = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("wrong_idx_pause", 32'(pause_req), 32'd0);
      chk("wrong_idx_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk);

    // Start and pause handshake, with a stray read while pausing
    bus.ioctl_index = 8'd4;
    bus.ioctl_upload = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.ioctl_rd = (c == 4);
      bus.ioctl_addr = 25'd5;
      @(posedge clk);
      #1;
      chk("pause_req_hold", 32'(pause_req), 32'd1);
      chk("pause_wait_hold", 32'(bus.ioctl_wait), 32'd1);
      chk("pause_no_ram_rd", 32'(bus.ram_rd), 32'd0);
      @(negedge clk);
    end
    bus.ioctl_rd = 1'b0;
    paused = 1'b1;
    @(posedge clk);
    #1;
    chk("paused_wait_low", 32'(bus.ioctl_wait), 32'd0);
    chk("paused_pause_req", 32'(pause_req), 32'd1);

    // Directed and random reads through the scoreboard
    mon_en = 1'b1;
    do_read(25'd5, 1'b0);
    do_read(25'd1024, 1'b0);
    do_read(25'h10005, 1'b0);
    do_read(25'd1023, 1'b1);
    do_read(25'd0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) a = 25'($urandom_range(0, 1023));
      else if (r == 7) a = 25'(1024 + $urandom_range(0, 64));
      else a = 25'($urandom);
      do_read(a, (a < LEN_W) && ($urandom_range(0, 3) == 0));
    end
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Abort during FETCH
    @(negedge clk);
    bus.ioctl_addr = 25'd7;
    bus.ioctl_rd = 1'b1;
    @(negedge clk);
    chk("abort_fetch_ram_rd", 32'(bus.ram_rd), 32'd1);
    bus.ioctl_rd = 1'b0;
    bus.ioctl_upload = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("abort_ram_rd", 32'(bus.ram_rd), 32'd0);
    chk("abort_pause_still", 32'(pause_req), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_pause_low", 32'(pause_req), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // Asynchronous reset in LATCH
    start_upload();
    chk("restart_busy", 32'(busy), 32'd1);
    bus.ioctl_addr = 25'd9;
    bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(posedge clk);
    #3;
    chk("latch_wait_high", 32'(bus.ioctl_wait), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pause", 32'(pause_req), 32'd0);
    chk("async_rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("async_rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_pause", 32'(pause_req), 32'd0);

`ifdef UPLOAD_AUTOREQ_EN
    // Writes at cycles 0 and 10: one pulse SETTLE cycles after the last write.
    pulses = 0;
    pulse_at = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      ram_wr_mon = (c == 0) || (c == 10);
      @(posedge clk);
      #1;
      if (bus.ioctl_upload_req) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
    end
    @(negedge clk);
    ram_wr_mon = 1'b0;
    chk("autoreq_pulse_count", 32'(pulses), 32'd1);
    chk("autoreq_pulse_cycle", 32'(pulse_at), 32'(10 + 20));

    // A completed upload clears dirty; no further pulses without writes.
    start_upload();
    mon_en = 1'b1;
    do_read(25'd3, 1'b0);
    mon_en = 1'b0;
    bus.ioctl_upload = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.ioctl_upload_req) pulses++;
    end
    chk("autoreq_no_repeat", 32'(pulses), 32'd0);

    // Write on the DONE cycle keeps dirty set and restarts the count.
    start_upload();
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    ram_wr_mon = 1'b1;
    pulses = 0;
    pulse_at = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.ioctl_upload_req) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
      @(negedge clk);
      ram_wr_mon = 1'b0;
    end
    chk("done_write_pulse_count", 32'(pulses), 32'd1);
    chk("done_write_pulse_cycle", 32'(pulse_at), 32'd20);
`else
    // Without the tracker the request output never moves.
    pulses = 0;
    pulse_at = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      ram_wr_mon = ((c % 5) == 0);
      @(posedge clk);
      #1;
      if (bus.ioctl_upload_req) pulses++;
    end
    @(negedge clk);
    ram_wr_mon = 1'b0;
    chk("no_autoreq", 32'(pulses), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
